// File: rtl/demux4_pkg.sv
// demux4_pkg: shared constants and types for the 1-to-4 stream demultiplexer.
package demux4_pkg;
   localparam int NUM_LANES = 4;
   localparam int CNT_W = 8;
   typedef logic [1:0] lane_sel_t;
endpackage

// File: rtl/demux_lane.sv
// demux_lane: one-entry lane buffer; a load on the same edge as a drain keeps the lane full.
module demux_lane #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] data_in,
   input  logic             ready_in,
   output logic             valid_out,
   output logic [WIDTH-1:0] data_out,
   output logic             full
);
   always_ff @(posedge clk) begin
      if (rst) begin
         full     <= 1'b0;
         data_out <= '0;
      end else begin
         if (load) data_out <= data_in;
         full <= load || (full && !ready_in);
      end
   end
   assign valid_out = full;
endmodule

// File: rtl/demux4_stream.sv
// demux4_stream: registered 1-to-4 stream demultiplexer with per-lane one-entry buffers.
// Optional per-lane delivered-beat counters on beat_cnt when DEMUX4_COUNT_EN is defined.
module demux4_stream
   import demux4_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [WIDTH-1:0]           in_data,
   input  lane_sel_t                  in_sel,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [NUM_LANES*WIDTH-1:0] out_data,
   output logic [NUM_LANES-1:0]       out_valid,
   input  logic [NUM_LANES-1:0]       out_ready
`ifdef DEMUX4_COUNT_EN
   ,
   output logic [NUM_LANES*CNT_W-1:0] beat_cnt
`endif
);
   logic [NUM_LANES-1:0] load, full;
   // Only the addressed lane can stall the producer.
   assign in_ready = !full[in_sel] || out_ready[in_sel];
   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      assign load[g] = in_valid && in_ready && (in_sel == lane_sel_t'(g));
      demux_lane #(.WIDTH(WIDTH)) u_lane (
         .clk      (clk),
         .rst      (rst),
         .load     (load[g]),
         .data_in  (in_data),
         .ready_in (out_ready[g]),
         .valid_out(out_valid[g]),
         .data_out (out_data[g*WIDTH +: WIDTH]),
         .full     (full[g])
      );
   end
`ifdef DEMUX4_COUNT_EN
   logic [CNT_W-1:0] cnt [NUM_LANES];
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_LANES; i++)
         cnt[i] <= rst ? '0 : cnt[i] + CNT_W'(out_valid[i] && out_ready[i]);
   end
   for (genvar c = 0; c < NUM_LANES; c++) begin : g_cnt
      assign beat_cnt[c*CNT_W +: CNT_W] = cnt[c];
   end
`endif
endmodule

// File: tb/tb_demux4_stream.sv
// tb_demux4_stream: scoreboard bench; per-lane expected-beat queues filled by the driver, drained by a monitor.
module tb_demux4_stream;
   logic        clk = 0;
   logic        rst = 1;
   logic [7:0]  in_data = 0;
   logic [1:0]  in_sel = 0;
   logic        in_valid = 0;
   logic        in_ready;
   logic [31:0] out_data;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready = 0;
`ifdef DEMUX4_COUNT_EN
   logic [31:0] beat_cnt;
`endif
   int checks = 0, errors = 0;
   logic [7:0] q [4][$];
   int cnt [4];

   demux4_stream #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
      .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
`ifdef DEMUX4_COUNT_EN
      , .beat_cnt(beat_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   // Monitor: each consumer handshake must deliver the oldest beat accepted for that lane.
   always @(negedge clk) begin
      if (!rst) begin
         for (int k = 0; k < 4; k++) begin
            chk($sformatf("valid%0d", k), 32'(out_valid[k]), 32'(q[k].size() != 0));
            if (out_valid[k] && out_ready[k] && q[k].size() != 0) begin
               chk($sformatf("data%0d", k), 32'(out_data[k*8 +: 8]), 32'(q[k].pop_front()));
               cnt[k] = (cnt[k] + 1) % 256;
            end
         end
      end
   end

   // Drive one cycle; returns acceptance and the sampled in_ready.
   task automatic step(input logic v, input logic [1:0] s, input logic [7:0] d, input logic [3:0] r,
                       output logic acc, output logic rdy);
      in_valid = v; in_sel = s; in_data = d; out_ready = r;
      @(negedge clk);
      rdy = in_ready;
      if (!rst) chk("in_ready", 32'(in_ready), 32'(q[s].size() == 0 || r[s]));
      acc = v && in_ready && !rst;
      @(posedge clk);
      if (rst) begin
         for (int k = 0; k < 4; k++) begin q[k].delete(); cnt[k] = 0; end
      end else if (acc) q[s].push_back(d);
      #1;
   endtask

   logic a, r;
   logic v;
   logic [1:0] s;
   logic [7:0] d;
   initial begin
      for (int k = 0; k < 4; k++) cnt[k] = 0;
      rst = 1;
      step(0, 0, 0, 0, a, r);
      step(0, 0, 0, 0, a, r);
      rst = 0;
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_data", out_data, 0);
      chk("rst_ready", 32'(in_ready), 1);
      // single beat
      step(1, 2, 8'hA5, 4'b1111, a, r);
      chk("single_valid", 32'(out_valid), 32'h4);
      chk("single_data", 32'(out_data[23:16]), 32'hA5);
      step(0, 0, 0, 4'b1111, a, r);
      chk("single_empty", 32'(out_valid), 0);
      // streaming
      for (int i = 1; i <= 8; i++) begin
         step(1, 2'(i - 1), 8'(i), 4'b1111, a, r);
         chk("stream_ready", 32'(r), 1);
      end
      step(0, 0, 0, 4'b1111, a, r);
      // blocked lane 1
      step(1, 1, 8'h31, 4'b1101, a, r);
      chk("blk_first_acc", 32'(a), 1);
      step(1, 1, 8'h32, 4'b1101, a, r);
      chk("blk_ready_low", 32'(r), 0);
      step(1, 1, 8'h32, 4'b1101, a, r);
      chk("blk_ready_low2", 32'(r), 0);
      step(1, 3, 8'h33, 4'b1101, a, r);
      chk("blk_lane3_acc", 32'(a), 1);
      step(0, 0, 0, 4'b1101, a, r);
      chk("blk_lane1_held", {out_valid[1], out_data[15:8]}, {1'b1, 8'h31});
      step(0, 0, 0, 4'b1111, a, r);
      step(0, 0, 0, 4'b1111, a, r);
      // same-lane drain and refill
      step(1, 0, 8'h11, 4'b0000, a, r);
      step(1, 0, 8'h22, 4'b0001, a, r);
      chk("refill_ready", 32'(r), 1);
      chk("refill_lane0", {out_valid[0], out_data[7:0]}, {1'b1, 8'h22});
      step(0, 0, 0, 4'b1111, a, r);
      // reset mid-operation
      step(1, 0, 8'h44, 4'b0000, a, r);
      step(1, 3, 8'h55, 4'b0000, a, r);
      chk("pre_rst_valid", 32'(out_valid), 32'h9);
      rst = 1;
      step(1, 1, 8'h66, 4'b1111, a, r);
      rst = 0;
      chk("mid_rst_valid", 32'(out_valid), 0);
      chk("mid_rst_data", out_data, 0);
      chk("mid_rst_ready", 32'(in_ready), 1);
      // randomized traffic; producer holds a stalled beat
      v = 0; s = 0; d = 0; a = 1;
      for (int i = 0; i < 600; i++) begin
         if (!(v && !a)) begin
            v = ($urandom_range(0, 3) != 0);
            s = 2'($urandom_range(0, 3));
            d = 8'($urandom);
         end
         step(v, s, d, 4'($urandom), a, r);
      end
      for (int i = 0; i < 3; i++) step(0, 0, 0, 4'b1111, a, r);
`ifdef DEMUX4_COUNT_EN
      chk("cnt_random", beat_cnt, {8'(cnt[3]), 8'(cnt[2]), 8'(cnt[1]), 8'(cnt[0])});
      rst = 1;
      step(0, 0, 0, 0, a, r);
      rst = 0;
      for (int i = 0; i < 257; i++) step(1, 2, 8'(i), 4'b1111, a, r);
      step(0, 0, 0, 4'b1111, a, r);
      chk("cnt_wrap", beat_cnt, 32'h0001_0000);
      chk("cnt_model", beat_cnt, {8'(cnt[3]), 8'(cnt[2]), 8'(cnt[1]), 8'(cnt[0])});
`endif
      for (int k = 0; k < 4; k++) chk($sformatf("drained%0d", k), 32'(q[k].size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/demux4_stream.md
# demux4_stream

Registered 1-to-4 stream demultiplexer: steers each accepted input beat to one of four output lanes chosen by a per-beat select, with a valid/ready handshake on every port. It is the distribution end of the 4->1 selection path. It fans one producer out to four consumers, and each lane holds one beat so a stalled consumer blocks only the beats addressed to it.

## Interface
Parameters:
- WIDTH, 8, data width of each beat.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  input beat payload.
- in_sel  input  2  destination lane for the current input beat (0..3).
- in_valid  input  1  input beat present.
- in_ready  output  1  block accepts the input beat this cycle.
- out_data  output  4*WIDTH  lane k payload at bits [k*WIDTH +: WIDTH].
- out_valid  output  4  lane k holds a beat.
- out_ready  input  4  consumer k accepts lane k this cycle.
- beat_cnt  output  32  lane k delivered-beat count at bits [k*8 +: 8]. Present only with DEMUX4_COUNT_EN.

## Operation
- Each lane is a one-entry register holding a full flag and a WIDTH-bit payload. out_valid[k] is the full flag of lane k.
- Input handshake: in_ready = !out_valid[in_sel] || out_ready[in_sel]. This path is combinational from in_sel and out_ready to in_ready.
- Accept: when in_valid && in_ready, lane in_sel loads in_data and sets its full flag at the next edge.
- Drain: when out_valid[k] && out_ready[k], lane k clears its full flag at the next edge, unless that lane is loaded on the same edge.
- Simultaneous drain and load of the same lane: the lane stays full and holds the new payload, with no bubble.
- Lanes are independent. A full, stalled lane k deasserts in_ready only while in_sel == k. Beats for other lanes continue to flow.
- Ordering: beats to the same lane are delivered in acceptance order. No ordering is defined across lanes.
- in_valid low: in_sel and in_data are ignored, and no lane changes except by drain.
- out_data[k] holds its last payload after a drain, because only a load updates it. Consumers sample it only while out_valid[k] is high.
- out_ready[k] asserted while lane k is empty has no effect.

## Timing
- Latency: a beat accepted at edge N is visible on out_valid and out_data at edge N (registered output, one cycle after it is presented). It can drain at edge N+1 at the earliest.
- Throughput: one beat per cycle to any lane whose consumer holds out_ready high.
- Reset (rst high at an edge): out_valid = 4'b0000, out_data = 0, and beat_cnt = 0. in_ready then reads 1.
- Reset mid-operation discards all held beats. No handshake completes on the reset edge.
- Input side protocol: the producer must hold in_data and in_sel stable while in_valid is high and in_ready is low.

## Configuration
- DEMUX4_COUNT_EN defined:
  - Four 8-bit counters, one per lane. Counter k increments on each lane-k output handshake (out_valid[k] && out_ready[k]).
  - Counters wrap 255 -> 0 and reset to 0.
  - beat_cnt port exists.
- DEMUX4_COUNT_EN undefined: no counters and no beat_cnt port. All other behaviour is identical.

## Structure
- Package demux4_pkg:
  - NUM_LANES = 4.
  - CNT_W = 8.
  - typedef lane_sel_t (logic [1:0]).
- Sub-module demux_lane: one-entry buffer with load, data_in, ready_in (consumer ready), valid_out, data_out and full-status outputs.
  - demux4_stream instantiates it four times.
  - demux4_stream decodes in_sel into per-lane load strobes and forms in_ready.

## Test plan
- Reset, then a single beat: in_data=8'hA5, in_sel=2, with out_ready=4'b1111.
  - Required: out_valid=4'b0100 and lane 2 data=A5 one cycle later, then 4'b0000 the next cycle.
- Back-to-back streaming: beats 8'h01..8'h08 with in_sel cycling 0,1,2,3, all out_ready high.
  - Required: in_ready stays high throughout, and each lane receives its two beats in order (lane 0 gets 01 then 05).
- Blocked lane: out_ready[1]=0, then three beats to lane 1 followed by a beat to lane 3.
  - Required: the first lane-1 beat is accepted.
  - Required: in_ready=0 while in_sel=1 and lane 1 is full.
  - Required: after the producer switches to in_sel=3, the lane-3 beat is accepted and delivered.
  - Required: lane 1 still holds the first beat.
- Same-lane drain and refill: lane 0 holds 8'h11 with out_ready[0]=1, and 8'h22 arrives for lane 0 in the same cycle.
  - Required: in_ready=1, and next cycle out_valid[0]=1 with data=22.
- Reset mid-operation: lanes 0 and 3 full, then rst pulsed for one cycle.
  - Required: out_valid=0 and out_data=0 after the edge, in_ready=1, and no consumer handshake is observed.
- With DEMUX4_COUNT_EN: 257 handshakes on lane 2.
  - Required: beat_cnt[23:16]=1, with all other lanes still at 0.
